screen_writer: RTL and testbench
================================

# screen_writer

Write-port controller for the 80x24 terminal screen RAM. Sequences every store into character memory, arbitrating between single-character writes from the terminal decoder and a multi-cycle clear engine used for power-up clear, erase-to-end-of-line, erase-to-end-of-screen and scroll line-clear. It drives the write side of the dual-port screen memory; the video generator reads the other port.

## Interface
- `COLS`, default 80: characters per row.
- `ROWS`, default 24: physical rows in memory.
- `clk` in 1: system clock, 50 MHz domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `char_valid` in 1: character write request.
- `char_ready` out 1: character request accepted when both valid and ready are high.
- `char_x` in 7: column.
- `char_row` in 5: physical memory row.
- `char_data` in 8: glyph code.
- `clr_valid` in 1: clear request.
- `clr_ready` out 1: clear request accepted when both valid and ready are high.
- `clr_mode` in 2: 0 = from x to end of line; 1 = from (x,row) to end of screen; 2 = whole row (x ignored); 3 = reserved, accepted with no writes.
- `clr_x` in 7: start column.
- `clr_row` in 5: start physical row.
- `topline` in 5: physical row currently shown at the top of the screen.
- `mem_addr` out 11: row*COLS + x.
- `mem_wdata` out 8: write data.
- `mem_we` out 1: write strobe, one cell per cycle.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: INIT, IDLE, CHAR, CLR.
- INIT is entered on reset release. It writes 0 to all ROWS*COLS cells, row 0..ROWS-1, x 0..COLS-1, one cell per cycle, then goes to IDLE. Both ready outputs are low during INIT.
- IDLE:
  - `clr_ready` = 1.
  - `char_ready` = !clr_valid, so a clear wins a simultaneous request.
  - An accepted char goes to CHAR; an accepted clear goes to CLR.
- CHAR: one write of the latched x, row and data, then back to IDLE.
- CLR:
  - Writes 0 from the latched x to COLS-1 on the current row.
  - At COLS-1 with mode 0 or 2: go to IDLE.
  - At COLS-1 with mode 1: next row = (row+1) mod ROWS. If next row == `topline` (sampled at acceptance), go to IDLE. Otherwise continue at x = 0 on the next row.
- Address: row*80 computed as (row<<6)+(row<<4), 11-bit result; maximum 1919.
- Out-of-range request, x > 79: x is clamped to 79.
- Out-of-range request, row > 23: accepted, no writes, returns to IDLE.
- Reset asserted mid-operation aborts immediately. The sequence restarts in INIT.

## Timing
- Reset values:
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `char_ready` = 0, `clr_ready` = 0, `busy` = 1 (INIT pending).
- All memory outputs are registered.
- Character accepted in cycle N: `mem_we` is high in cycle N+1 only. `char_ready` is high again in N+2.
- Back-to-back characters: one write every 2 cycles.
- Clear accepted in cycle N: writes occupy cycles N+1 .. N+W. IDLE is reached in N+W+1.
  - Modes 0 and 2: W = 80 - x, with x forced to 0 for mode 2.
  - Mode 1: W = (80 - x) + 80*k, where k = rows strictly between the start row and `topline`, counting with wrap.
- INIT takes exactly 1920 write cycles starting the cycle after reset release.
- `busy` falls in the same cycle the FSM enters IDLE.

## Configuration
- `SCREEN_WRITER_FIFO_EN` defined: adds a 4-entry character FIFO in front of CHAR.
  - `char_ready` = FIFO not full, in any state except INIT.
  - The FIFO drains one entry per cycle whenever the FSM is in IDLE. Each drained entry takes one write and no extra CHAR cycle.
  - To preserve ordering, `clr_ready` is low while the FIFO is non-empty.
- Undefined: no FIFO; behaviour as in Operation.

## Structure
- Shared package `screen_pkg` holds COLS, ROWS, the clr_mode encodings (CLR_EOL, CLR_EOS, CLR_LINE) and the FSM state enum.
- One sub-module, `screen_addr`: combinational row*80+x mapping, shared with the video generator's read path.
- FIFO (when enabled) is inline: 2-bit pointers plus a count.

## Test plan
- Reset release: exactly 1920 writes of 0, addresses 0..1919 ascending, `busy` drops on cycle 1921, `char_ready` rises.
- Char 'A' (0x41) at x=5, row=2: a single write, addr 165, data 0x41, one cycle after acceptance.
- Clear mode 0, x=70, row=23: 10 writes, addr 1910..1919, then IDLE.
- Clear mode 1, x=78, row=22, topline=1: writes addr 1838, 1839, 1840..1919, 0..79 (162 total), then stop.
- Simultaneous char and clr valid in IDLE: the clear is accepted and `char_ready` stays low until the clear completes; then the char is written.
- Reset pulsed mid-clear: `mem_we` drops asynchronously and INIT restarts from addr 0. With `SCREEN_WRITER_FIFO_EN`: 4 chars queued during a clear, written in order after it completes, 1 per cycle.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared screen geometry, clear-mode encodings and write-controller FSM states.
package screen_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 24;
  localparam int FIFO_DEPTH = 4;

  localparam logic [1:0] CLR_EOL  = 2'd0;
  localparam logic [1:0] CLR_EOS  = 2'd1;
  localparam logic [1:0] CLR_LINE = 2'd2;
  localparam logic [1:0] CLR_RSVD = 2'd3;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CHAR, ST_CLR} state_t;

  typedef struct packed {
    logic [6:0] x;
    logic [4:0] row;
    logic [7:0] data;
  } char_req_t;

  function automatic logic [6:0] clamp_x(input logic [6:0] x, input int cols);
    return (int'(x) > cols - 1) ? 7'(cols - 1) : x;
  endfunction
endpackage

// File: rtl/screen_addr.sv
// Combinational (row, x) -> linear screen RAM address; also used by the video read path.
module screen_addr #(
  parameter int COLS = 80
) (
  input  logic [6:0]  x,
  input  logic [4:0]  row,
  output logic [10:0] addr
);
  generate
    if (COLS == 80) begin : g_shift
      // row*80 as row*64 + row*16 keeps this to two adders
      assign addr = {row, 6'd0} + {2'b00, row, 4'd0} + {4'd0, x};
    end else begin : g_mul
      assign addr = 11'(int'(row) * COLS + int'(x));
    end
  endgenerate
endmodule

// File: rtl/screen_writer.sv
// Write-port controller for the screen RAM: power-up clear, char writes, erase engine.
// Define SCREEN_WRITER_FIFO_EN to put a 4-entry character FIFO in front of the writer.
module screen_writer import screen_pkg::*; #(
  parameter int COLS = screen_pkg::COLS,
  parameter int ROWS = screen_pkg::ROWS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [6:0]  char_x,
  input  logic [4:0]  char_row,
  input  logic [7:0]  char_data,
  input  logic        clr_valid,
  output logic        clr_ready,
  input  logic [1:0]  clr_mode,
  input  logic [6:0]  clr_x,
  input  logic [4:0]  clr_row,
  input  logic [4:0]  topline,
  output logic [10:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        busy
);
  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);

  state_t      state;
  logic [6:0]  cur_x, step_x, sel_x;
  logic [4:0]  cur_row, step_row, sel_row, nxt_row, top;
  logic [1:0]  mode;
  logic [7:0]  sel_data;
  logic [10:0] sel_addr;
  logic        last_col, last_cell, clr_go, char_go, pop;
  char_req_t   head;

  assign busy    = (state != ST_IDLE);
  assign clr_go  = clr_valid && clr_ready;
  assign char_go = char_valid && char_ready;

`ifdef SCREEN_WRITER_FIFO_EN
  char_req_t  fifo [FIFO_DEPTH];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;

  assign pop        = (state == ST_IDLE) && (count != 3'd0);
  assign clr_ready  = (state == ST_IDLE) && (count == 3'd0);
  assign char_ready = (state != ST_INIT) && (count != 3'(FIFO_DEPTH));
  assign head       = fifo[rd_ptr];

  always_ff @(posedge clk) begin
    if (char_go) fifo[wr_ptr] <= '{x: char_x, row: char_row, data: char_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (char_go) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, char_go} - {2'b00, pop};
    end
  end
`else
  assign pop        = 1'b0;
  assign clr_ready  = (state == ST_IDLE);
  assign char_ready = (state == ST_IDLE) && !clr_valid;
  assign head       = '0;
`endif

  // Next cell to write: either a fresh request or one step along the current sweep.
  always_comb begin
    last_col  = (cur_x == COL_MAX);
    nxt_row   = (cur_row == ROW_MAX) ? 5'd0 : cur_row + 5'd1;
    step_x    = last_col ? 7'd0 : cur_x + 7'd1;
    step_row  = last_col ? nxt_row : cur_row;
    last_cell = last_col && ((state == ST_INIT) ? (cur_row == ROW_MAX)
                                                : (mode != CLR_EOS || nxt_row == top));
    sel_x     = step_x;
    sel_row   = step_row;
    sel_data  = 8'd0;
    if (state == ST_INIT && !mem_we) begin
      sel_x   = cur_x;
      sel_row = cur_row;
    end else if (state == ST_IDLE) begin
      if (pop) begin
        sel_x    = clamp_x(head.x, COLS);
        sel_row  = head.row;
        sel_data = head.data;
      end else if (clr_go) begin
        sel_x   = (clr_mode == CLR_LINE) ? 7'd0 : clamp_x(clr_x, COLS);
        sel_row = clr_row;
      end else begin
        sel_x    = clamp_x(char_x, COLS);
        sel_row  = char_row;
        sel_data = char_data;
      end
    end
  end

  screen_addr #(.COLS(COLS)) u_addr (
    .x   (sel_x),
    .row (sel_row),
    .addr(sel_addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      cur_x     <= 7'd0;
      cur_row   <= 5'd0;
      mode      <= CLR_EOL;
      top       <= 5'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 11'd0;
      mem_wdata <= 8'd0;
    end else begin
      case (state)
        ST_INIT: begin
          // mem_we low here only on the very first INIT cycle after reset
          mem_we    <= 1'b1;
          mem_addr  <= sel_addr;
          mem_wdata <= 8'd0;
          if (mem_we) begin
            if (last_cell) begin
              state  <= ST_IDLE;
              mem_we <= 1'b0;
            end else begin
              cur_x   <= step_x;
              cur_row <= step_row;
            end
          end
        end
        ST_IDLE: begin
          mem_we <= 1'b0;
          if (pop) begin
            mem_we    <= (sel_row <= ROW_MAX);
            mem_addr  <= sel_addr;
            mem_wdata <= sel_data;
          end else if (clr_go) begin
            mode    <= clr_mode;
            top     <= topline;
            cur_x   <= sel_x;
            cur_row <= sel_row;
            if (clr_row <= ROW_MAX && clr_mode != CLR_RSVD) begin
              state     <= ST_CLR;
              mem_we    <= 1'b1;
              mem_addr  <= sel_addr;
              mem_wdata <= 8'd0;
            end
          end
`ifndef SCREEN_WRITER_FIFO_EN
          else if (char_go) begin
            state     <= ST_CHAR;
            mem_we    <= (char_row <= ROW_MAX);
            mem_addr  <= sel_addr;
            mem_wdata <= sel_data;
          end
`endif
        end
        ST_CHAR: begin
          mem_we <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_CLR: begin
          if (last_cell) begin
            state  <= ST_IDLE;
            mem_we <= 1'b0;
          end else begin
            cur_x     <= step_x;
            cur_row   <= step_row;
            mem_we    <= 1'b1;
            mem_addr  <= sel_addr;
            mem_wdata <= 8'd0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_screen_writer.sv
// Directed bench for screen_writer: init sweep, char writes, clear modes, arbitration, reset abort.
module tb_screen_writer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        char_valid = 1'b0, clr_valid = 1'b0;
  logic        char_ready, clr_ready, mem_we, busy;
  logic [6:0]  char_x = '0, clr_x = '0;
  logic [4:0]  char_row = '0, clr_row = '0, topline = '0;
  logic [7:0]  char_data = '0, mem_wdata;
  logic [1:0]  clr_mode = '0;
  logic [10:0] mem_addr;

  int checks = 0;
  int failures = 0;
  int wa[$];
  bit nz;

  screen_writer dut (
    .clk(clk), .reset_n(reset_n),
    .char_valid(char_valid), .char_ready(char_ready),
    .char_x(char_x), .char_row(char_row), .char_data(char_data),
    .clr_valid(clr_valid), .clr_ready(clr_ready), .clr_mode(clr_mode),
    .clr_x(clr_x), .clr_row(clr_row), .topline(topline),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Record writes each cycle until busy is low; ncyc is the cycle index where idle is seen.
  task automatic capture(input bit drop_char, output int ncyc, output bit cr_hi);
    ncyc = -1;
    cr_hi = 1'b0;
    nz = 1'b0;
    wa.delete();
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (k == 1) begin
        clr_valid = 1'b0;
        if (drop_char) char_valid = 1'b0;
      end
      if (mem_we) begin
        wa.push_back(int'(mem_addr));
        if (mem_wdata != 8'd0) nz = 1'b1;
      end
      if (busy && char_ready) cr_hi = 1'b1;
      if (!busy) begin
        ncyc = k;
        return;
      end
    end
  endtask

  task automatic start_clr(input logic [1:0] m, input int x, input int row, input int top);
    clr_valid = 1'b1;
    clr_mode  = m;
    clr_x     = 7'(x);
    clr_row   = 5'(row);
    topline   = 5'(top);
  endtask

  initial begin
    int  n, bad, cnt;
    bit  cr;

    repeat (3) @(negedge clk);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_char_ready", char_ready, 0);
    chk("rst_clr_ready", clr_ready, 0);
    chk("rst_busy", busy, 1);

    reset_n = 1'b1;
    capture(1'b1, n, cr);
    bad = 0;
    foreach (wa[i]) if (wa[i] != i) bad++;
    chk("init_writes", wa.size(), 1920);
    chk("init_order", bad, 0);
    chk("init_zero", nz, 0);
    chk("init_idle_cycle", n, 1921);
    chk("init_char_ready", char_ready, 1);
    chk("init_clr_ready", clr_ready, 1);

    // 'A' at x=5 row=2 -> addr 165, one cycle after acceptance
    char_valid = 1'b1; char_x = 7'd5; char_row = 5'd2; char_data = 8'h41;
    #1 chk("charA_ready", char_ready, 1);
    @(negedge clk);
    char_valid = 1'b0;
    chk("charA_we", mem_we, 1);
    chk("charA_addr", mem_addr, 165);
    chk("charA_data", mem_wdata, 8'h41);
    chk("charA_ready_low", char_ready, 0);
    @(negedge clk);
    chk("charA_we_pulse", mem_we, 0);
    chk("charA_ready_again", char_ready, 1);

    // x beyond the line clamps to column 79
    char_valid = 1'b1; char_x = 7'd100; char_row = 5'd0; char_data = 8'h5A;
    @(negedge clk);
    char_valid = 1'b0;
    chk("clamp_addr", mem_addr, 79);
    chk("clamp_we", mem_we, 1);
    @(negedge clk);

    // row beyond the screen is accepted but writes nothing
    char_valid = 1'b1; char_x = 7'd3; char_row = 5'd30;
    @(negedge clk);
    char_valid = 1'b0;
    chk("badrow_we", mem_we, 0);
    @(negedge clk);

    // held request: one write every two cycles
    char_valid = 1'b1; char_x = 7'd0; char_row = 5'd0; char_data = 8'h01;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_we) cnt++;
    end
    char_valid = 1'b0;
    chk("b2b_writes", cnt, 3);
    @(negedge clk);

    start_clr(2'd0, 70, 23, 0);
    capture(1'b1, n, cr);
    chk("eol_writes", wa.size(), 10);
    chk("eol_first", wa.size() > 0 ? wa[0] : -1, 1910);
    chk("eol_last", wa.size() > 0 ? wa[wa.size()-1] : -1, 1919);
    chk("eol_cycles", n, 11);
    chk("eol_zero", nz, 0);

    start_clr(2'd2, 40, 3, 0);
    capture(1'b1, n, cr);
    chk("line_writes", wa.size(), 80);
    chk("line_first", wa.size() > 0 ? wa[0] : -1, 240);
    chk("line_last", wa.size() > 0 ? wa[wa.size()-1] : -1, 319);

    // rows 22, 23, 0 then stop before topline row 1
    start_clr(2'd1, 78, 22, 1);
    capture(1'b1, n, cr);
    bad = 0;
    foreach (wa[i]) if (wa[i] != ((i < 82) ? 1838 + i : i - 82)) bad++;
    chk("eos_writes", wa.size(), 162);
    chk("eos_order", bad, 0);
    chk("eos_cycles", n, 163);

    start_clr(2'd3, 0, 4, 0);
    capture(1'b1, n, cr);
    chk("rsvd_writes", wa.size(), 0);
    chk("rsvd_cycles", n, 1);

    start_clr(2'd0, 0, 25, 0);
    capture(1'b1, n, cr);
    chk("clr_badrow_writes", wa.size(), 0);

`ifdef SCREEN_WRITER_FIFO_EN
    // four chars queued during a clear drain in order, one per cycle
    start_clr(2'd0, 0, 5, 0);
    @(negedge clk);
    clr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      char_valid = 1'b1; char_x = 7'(i); char_row = 5'd6; char_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    char_valid = 1'b0;
    wa.delete();
    bad = 0; cnt = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mem_we && mem_wdata != 8'd0) begin
        if (cnt >= 0 && k != cnt + 1) bad++;
        if (mem_wdata != 8'(8'h10 + wa.size())) bad++;
        cnt = k;
        wa.push_back(int'(mem_addr));
      end
    end
    chk("fifo_writes", wa.size(), 4);
    foreach (wa[i]) chk("fifo_addr", wa[i], 480 + i);
    chk("fifo_order_rate", bad, 0);
`else
    // clear wins; char waits until the clear is done
    start_clr(2'd0, 75, 0, 0);
    char_valid = 1'b1; char_x = 7'd1; char_row = 5'd1; char_data = 8'h33;
    #1 chk("arb_char_ready", char_ready, 0);
    capture(1'b0, n, cr);
    chk("arb_clr_writes", wa.size(), 5);
    chk("arb_char_held", cr, 0);
    @(negedge clk);
    char_valid = 1'b0;
    chk("arb_char_we", mem_we, 1);
    chk("arb_char_addr", mem_addr, 81);
    chk("arb_char_data", mem_wdata, 8'h33);
    @(negedge clk);
`endif

    // reset mid-clear aborts at once and restarts the init sweep
    start_clr(2'd1, 0, 0, 0);
    @(negedge clk);
    clr_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_pre_we", mem_we, 1);
    #2 reset_n = 1'b0;
    #1 chk("abort_we", mem_we, 0);
    chk("abort_busy", busy, 1);
    @(negedge clk);
    reset_n = 1'b1;
    capture(1'b1, n, cr);
    chk("reinit_first", wa.size() > 0 ? wa[0] : -1, 0);
    chk("reinit_writes", wa.size(), 1920);
    chk("reinit_cycles", n, 1921);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
